uart_core_param: RTL

- Parametrised full-duplex UART: the next generation of the fixed 8N1 transceiver.
- Configurable data width, parity mode, stop-bit count and RX oversampling ratio.
- Adds parity/framing error flags, a TX busy indicator and false-start rejection.
- Sits between the system bus logic and the external serial pins; drop-in successor to the existing top-level TX/RX pair.

---
 rtl/uart_core_param.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART transceiver.
//   Shared tick generator (DIV = CLK_FREQ/(BAUD*OVERSAMPLE), minimum 1), a TX
//   serialiser and an oversampling RX deserialiser with parity/framing checks.
// Optional feature: define UART_CORE_LOOPBACK_EN to add the 'loopback' input,
//   which routes the internal TX output into the RX synchroniser and holds
//   tx_line high.
// Ports:
//   clk, reset (async, active-low)
//   tx_start, tx_data -> tx_busy, tx_done, tx_line
//   rx_line -> rx_data, rx_done, rx_parity_err, rx_frame_err
//   loopback (only with UART_CORE_LOOPBACK_EN)
module uart_core_param #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_line,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
`ifdef UART_CORE_LOOPBACK_EN
    ,
    input  logic                 loopback
`endif
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W    = $clog2(OVERSAMPLE);
    localparam int unsigned HALF    = OVERSAMPLE / 2;
    localparam int unsigned BIT_W   = $clog2(DATA_BITS + 1);
    localparam bit          PAR_EN  = (PARITY != 0);
    localparam bit          PAR_ODD = (PARITY == 2);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_c;

    assign tick_c    = (div_cnt_q == DIV_W'(DIV - 1));
    assign div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_cnt_q <= '0;
        else        div_cnt_q <= div_cnt_d;
    end

    // ---------------- TX ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic [OS_W-1:0]      tx_os_q, tx_os_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tx_load;
    logic                 tx_bit_end_c;

    assign tx_bit_end_c = tick_c && (tx_os_q == OS_W'(OVERSAMPLE - 1));

    // The last stop-bit edge also acts as the IDLE decision point, so a held
    // tx_start chains the next frame with no gap on the line.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_line_d  = tx_line_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        tx_load    = 1'b0;
        if (tick_c && (tx_state_q != TX_IDLE)) tx_os_d = tx_os_q + OS_W'(1);
        case (tx_state_q)
            TX_IDLE: tx_load = tx_start;
            TX_START: if (tx_bit_end_c) begin
                tx_state_d = TX_DATA;
                tx_line_d  = tx_shift_q[0];
            end
            TX_DATA: if (tx_bit_end_c) begin
                if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
                    tx_bit_d = '0;
                    if (PAR_EN) begin
                        tx_state_d = TX_PARITY;
                        tx_line_d  = tx_par_q;
                    end else begin
                        tx_state_d = TX_STOP;
                        tx_line_d  = 1'b1;
                    end
                end else begin
                    tx_bit_d   = tx_bit_q + BIT_W'(1);
                    tx_shift_d = tx_shift_q >> 1;
                    tx_line_d  = tx_shift_q[1];
                end
            end
            TX_PARITY: if (tx_bit_end_c) begin
                tx_state_d = TX_STOP;
                tx_line_d  = 1'b1;
                tx_bit_d   = '0;
            end
            TX_STOP: if (tx_bit_end_c) begin
                if (tx_bit_q == BIT_W'(STOP_BITS - 1)) begin
                    tx_done_d  = 1'b1;
                    tx_busy_d  = 1'b0;
                    tx_state_d = TX_IDLE;
                    tx_load    = tx_start;
                end else begin
                    tx_bit_d = tx_bit_q + BIT_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_state_d = TX_START;
            tx_shift_d = tx_data;
            tx_par_d   = (^tx_data) ^ PAR_ODD;
            tx_os_d    = '0;
            tx_bit_d   = '0;
            tx_line_d  = 1'b0;
            tx_busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_line_q  <= tx_line_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

    // ---------------- RX source select ----------------
    logic rx_src_c;
`ifdef UART_CORE_LOOPBACK_EN
    assign rx_src_c = loopback ? tx_line_q : rx_line;
    assign tx_line  = tx_line_q | loopback;
`else
    assign rx_src_c = rx_line;
    assign tx_line  = tx_line_q;
`endif

    // ---------------- RX ----------------
    logic                 sync1_q, sync2_q, prev_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [OS_W-1:0]      rx_os_q, rx_os_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_facc_q, rx_facc_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_fall_c, rx_mid_c, rx_half_c;

    assign rx_fall_c = prev_q & ~sync2_q;
    assign rx_mid_c  = tick_c && (rx_os_q == OS_W'(OVERSAMPLE - 1));
    assign rx_half_c = tick_c && (rx_os_q == OS_W'(HALF - 1));

    // Sample points: half a bit after the start edge, then every full bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_os_d    = rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_facc_d  = rx_facc_q;
        rx_data_d  = rx_data_q;
        rx_done_d  = 1'b0;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        if (tick_c && (rx_state_q != RX_IDLE)) rx_os_d = rx_os_q + OS_W'(1);
        case (rx_state_q)
            RX_IDLE: if (rx_fall_c) begin
                rx_state_d = RX_START;
                rx_os_d    = '0;
            end
            RX_START: if (rx_half_c) begin
                rx_os_d = '0;
                if (sync2_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = '0;
                    rx_facc_d  = 1'b0;
                end
            end
            RX_DATA: if (rx_mid_c) begin
                rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bit_q == BIT_W'(DATA_BITS - 1)) begin
                    rx_bit_d   = '0;
                    rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
                end else begin
                    rx_bit_d = rx_bit_q + BIT_W'(1);
                end
            end
            RX_PARITY: if (rx_mid_c) begin
                rx_par_d   = sync2_q;
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_mid_c) begin
                if (rx_bit_q == BIT_W'(STOP_BITS - 1)) begin
                    rx_done_d  = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_perr_d  = PAR_EN && (rx_par_q != ((^rx_shift_q) ^ PAR_ODD));
                    rx_ferr_d  = rx_facc_q | ~sync2_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_facc_d = rx_facc_q | ~sync2_q;
                    rx_bit_d  = rx_bit_q + BIT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_facc_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            sync1_q    <= rx_src_c;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_state_q <= rx_state_d;
            rx_os_q    <= rx_os_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_facc_q  <= rx_facc_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_done       = rx_done_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule
